// File: rtl/ysyx_22040759_axi_sram_pkg.sv
// ysyx_22040759_axi_sram_pkg: AXI response/burst encodings, engine states and request classification
package ysyx_22040759_axi_sram_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  typedef enum logic {R_IDLE, R_BEAT} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  // Decode errors win over unsupported burst/size; WRAP and the reserved encoding share burst[1].
  function automatic logic [1:0] req_resp(input logic in_range, input logic [1:0] burst, input logic [2:0] size);
    return !in_range ? RESP_DECERR : (burst[1] || size > 3'd3) ? RESP_SLVERR : RESP_OKAY;
  endfunction
endpackage

// File: rtl/ysyx_22040759_axi_sram_if.sv
// ysyx_22040759_axi_sram_if: AXI4 bus bundle between the CPU-side initiator and the SRAM responder
interface ysyx_22040759_axi_sram_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1
);
  logic                    aw_valid, aw_ready;
  logic [ADDR_WIDTH-1:0]   aw_addr;
  logic [ID_WIDTH-1:0]     aw_id;
  logic [USER_WIDTH-1:0]   aw_user;
  logic [7:0]              aw_len;
  logic [2:0]              aw_size;
  logic [1:0]              aw_burst;
  logic [2:0]              aw_prot;
  logic                    aw_lock;
  logic [3:0]              aw_cache, aw_qos;
  logic                    w_valid, w_ready, w_last;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic                    b_valid, b_ready;
  logic [1:0]              b_resp;
  logic [ID_WIDTH-1:0]     b_id;
  logic [USER_WIDTH-1:0]   b_user;
  logic                    ar_valid, ar_ready;
  logic [ADDR_WIDTH-1:0]   ar_addr;
  logic [ID_WIDTH-1:0]     ar_id;
  logic [USER_WIDTH-1:0]   ar_user;
  logic [7:0]              ar_len;
  logic [2:0]              ar_size;
  logic [1:0]              ar_burst;
  logic [2:0]              ar_prot;
  logic                    ar_lock;
  logic [3:0]              ar_cache, ar_qos;
  logic                    r_valid, r_ready, r_last;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [1:0]              r_resp;
  logic [ID_WIDTH-1:0]     r_id;
  logic [USER_WIDTH-1:0]   r_user;
  modport master (
    output aw_valid, aw_addr, aw_id, aw_user, aw_len, aw_size, aw_burst, aw_prot, aw_lock, aw_cache, aw_qos,
    input  aw_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_resp, b_id, b_user,
    output b_ready,
    output ar_valid, ar_addr, ar_id, ar_user, ar_len, ar_size, ar_burst, ar_prot, ar_lock, ar_cache, ar_qos,
    input  ar_ready,
    input  r_valid, r_data, r_resp, r_last, r_id, r_user,
    output r_ready
  );
  modport slave (
    input  aw_valid, aw_addr, aw_id, aw_user, aw_len, aw_size, aw_burst, aw_prot, aw_lock, aw_cache, aw_qos,
    output aw_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_resp, b_id, b_user,
    input  b_ready,
    input  ar_valid, ar_addr, ar_id, ar_user, ar_len, ar_size, ar_burst, ar_prot, ar_lock, ar_cache, ar_qos,
    output ar_ready,
    output r_valid, r_data, r_resp, r_last, r_id, r_user,
    input  r_ready
  );
endinterface

// File: rtl/ysyx_22040759_axi_sram_mem.sv
// ysyx_22040759_axi_sram_mem: 1R1W word array with enabled registered read and byte-enable write
module ysyx_22040759_axi_sram_mem #(
  parameter int DEPTH_LOG2 = 12,
  parameter int DATA_WIDTH = 64
) (
  input  logic                    clock,
  input  logic                    re,
  input  logic [DEPTH_LOG2-1:0]   raddr,
  output logic [DATA_WIDTH-1:0]   rdata,
  input  logic                    we,
  input  logic [DEPTH_LOG2-1:0]   waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb
);
  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  // Read data only moves when enabled, so a stalled beat keeps its value even if the word is rewritten.
  always_ff @(posedge clock)
    if (re) rdata <= mem[raddr];
  // Byte lanes with a clear strobe keep their old contents.
  always_ff @(posedge clock)
    if (we)
      for (int i = 0; i < DATA_WIDTH/8; i++)
        if (wstrb[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
endmodule

// File: rtl/ysyx_22040759_axi_sram.sv
// ysyx_22040759_axi_sram: AXI4 responder with independent read/write burst engines over a word SRAM
module ysyx_22040759_axi_sram
  import ysyx_22040759_axi_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH_LOG2 = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000
) (
  input logic clock,
  input logic reset,
  ysyx_22040759_axi_sram_if.slave axi
);
  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> (DEPTH_LOG2 + 3)) == '0);
  endfunction
  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = (a - BASE_ADDR) >> 3;
    return DEPTH_LOG2'(off);
  endfunction
  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a, input logic [2:0] size, input logic [1:0] burst);
    return burst == BURST_FIXED ? a : a + (ADDR_WIDTH'(1) << size);
  endfunction
  r_state_e              r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic [ID_WIDTH-1:0]   r_id_q;
  logic [USER_WIDTH-1:0] r_user_q;
  w_state_e              w_state;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [7:0]            w_len, w_cnt;
  logic [2:0]            w_size;
  logic [1:0]            w_burst, w_err;
  logic                  w_bad;
  logic [ID_WIDTH-1:0]   b_id_q;
  logic [USER_WIDTH-1:0] b_user_q;
  logic [DATA_WIDTH-1:0] rdata;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs, re, we;
  logic [ADDR_WIDTH-1:0] r_nxt, w_nxt;
  logic unused;
  assign ar_hs = axi.ar_valid && axi.ar_ready;
  assign r_hs  = axi.r_valid && axi.r_ready;
  assign aw_hs = axi.aw_valid && axi.aw_ready;
  assign w_hs  = axi.w_valid && axi.w_ready;
  assign b_hs  = axi.b_valid && axi.b_ready;
  assign r_nxt = next_addr(r_addr, r_size, r_burst);
  assign w_nxt = next_addr(w_addr, w_size, w_burst);
  assign re = ar_hs || (r_hs && !axi.r_last);
  assign we = w_hs && w_err == RESP_OKAY;
  assign axi.r_data = (axi.r_valid && axi.r_resp == RESP_OKAY) ? rdata : '0;
  assign axi.r_id   = r_id_q;
  assign axi.r_user = r_user_q;
  assign axi.b_id   = b_id_q;
  assign axi.b_user = b_user_q;
  assign unused = ^{axi.aw_prot, axi.aw_lock, axi.aw_cache, axi.aw_qos, axi.ar_prot, axi.ar_lock, axi.ar_cache, axi.ar_qos};
  ysyx_22040759_axi_sram_mem #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_WIDTH(DATA_WIDTH)) u_mem (
    .clock (clock),
    .re    (re),
    .raddr (ar_hs ? word_idx(axi.ar_addr) : word_idx(r_nxt)),
    .rdata (rdata),
    .we    (we),
    .waddr (word_idx(w_addr)),
    .wdata (axi.w_data),
    .wstrb (axi.w_strb)
  );
  // Read engine: latch the request on AR, then present one beat at a time until the last is taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= R_IDLE;
      axi.ar_ready  <= 1'b0;
      axi.r_valid   <= 1'b0;
      axi.r_last    <= 1'b0;
      axi.r_resp    <= RESP_OKAY;
      r_id_q        <= '0;
      r_user_q      <= '0;
      r_addr        <= '0;
      r_len         <= '0;
      r_cnt         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
    end else if (r_state == R_IDLE) begin
      axi.ar_ready <= !ar_hs;
      if (ar_hs) begin
        r_state     <= R_BEAT;
        r_addr      <= axi.ar_addr;
        r_len       <= axi.ar_len;
        r_size      <= axi.ar_size;
        r_burst     <= axi.ar_burst;
        r_cnt       <= '0;
        r_id_q      <= axi.ar_id;
        r_user_q    <= axi.ar_user;
        axi.r_valid <= 1'b1;
        axi.r_last  <= axi.ar_len == 8'd0;
        axi.r_resp  <= req_resp(in_range(axi.ar_addr), axi.ar_burst, axi.ar_size);
      end
    end else if (r_hs) begin
      if (axi.r_last) begin
        r_state      <= R_IDLE;
        axi.r_valid  <= 1'b0;
        axi.r_last   <= 1'b0;
        axi.ar_ready <= 1'b1;
      end else begin
        r_addr     <= r_nxt;
        r_cnt      <= r_cnt + 8'd1;
        axi.r_last <= r_cnt + 8'd1 == r_len;
      end
    end
  end
  // Write engine: AW, then exactly len+1 W beats, then hold the response until taken.
  always_ff @(posedge clock) begin
    if (reset) begin
      w_state      <= W_IDLE;
      axi.aw_ready <= 1'b0;
      axi.w_ready  <= 1'b0;
      axi.b_valid  <= 1'b0;
      axi.b_resp   <= RESP_OKAY;
      b_id_q       <= '0;
      b_user_q     <= '0;
      w_addr       <= '0;
      w_len        <= '0;
      w_cnt        <= '0;
      w_size       <= '0;
      w_burst      <= '0;
      w_err        <= RESP_OKAY;
      w_bad        <= 1'b0;
    end else if (w_state == W_IDLE) begin
      axi.aw_ready <= !aw_hs;
      if (aw_hs) begin
        w_state     <= W_DATA;
        w_addr      <= axi.aw_addr;
        w_len       <= axi.aw_len;
        w_size      <= axi.aw_size;
        w_burst     <= axi.aw_burst;
        w_cnt       <= '0;
        w_bad       <= 1'b0;
        w_err       <= req_resp(in_range(axi.aw_addr), axi.aw_burst, axi.aw_size);
        b_id_q      <= axi.aw_id;
        b_user_q    <= axi.aw_user;
        axi.w_ready <= 1'b1;
      end
    end else if (w_state == W_DATA) begin
      if (w_hs) begin
        w_addr <= w_nxt;
        w_cnt  <= w_cnt + 8'd1;
        if (w_cnt == w_len) begin
          w_state     <= W_RESP;
          axi.w_ready <= 1'b0;
          axi.b_valid <= 1'b1;
          axi.b_resp  <= w_err != RESP_OKAY ? w_err : (w_bad || !axi.w_last) ? RESP_SLVERR : RESP_OKAY;
        end else begin
          w_bad <= w_bad || axi.w_last;
        end
      end
    end else if (b_hs) begin
      w_state      <= W_IDLE;
      axi.b_valid  <= 1'b0;
      axi.aw_ready <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ysyx_22040759_axi_sram.sv
// tb_ysyx_22040759_axi_sram: randomized AXI master against an array model of the SRAM
module tb_ysyx_22040759_axi_sram;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int WORDS = 4096;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [63:0] model [WORDS];
  int tests = 0;
  int fails = 0;
  always #5 clock = ~clock;
  ysyx_22040759_axi_sram_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4), .USER_WIDTH(1)) axi ();
  ysyx_22040759_axi_sram #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4), .USER_WIDTH(1), .DEPTH_LOG2(12), .BASE_ADDR(BASE)) u_dut (
    .clock (clock),
    .reset (reset),
    .axi   (axi.slave)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] exp_resp(input logic [31:0] a, input logic [1:0] burst, input logic [2:0] size);
    if (a < BASE || a >= BASE + 32'(8 * WORDS)) return 2'b11;
    if (burst >= 2'd2 || size > 3'd3) return 2'b10;
    return 2'b00;
  endfunction
  function automatic int beat_idx(input logic [31:0] a, input logic [2:0] size, input logic [1:0] burst, input int i);
    logic [31:0] b;
    b = (burst == 2'd0) ? a : a + 32'(i) * (32'd1 << size);
    return int'(((b - BASE) >> 3) % WORDS);
  endfunction
  task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst, input logic [3:0] id, input logic user);
    int n;
    axi.ar_addr = addr; axi.ar_len = len; axi.ar_size = size; axi.ar_burst = burst;
    axi.ar_id = id; axi.ar_user = user; axi.ar_prot = 3'($urandom); axi.ar_cache = 4'($urandom);
    axi.ar_valid = 1'b1;
    n = 0;
    while (!axi.ar_ready && n < 50) begin @(negedge clock); n++; end
    check("ar_ready", axi.ar_ready, 1);
    @(negedge clock);
    axi.ar_valid = 1'b0;
    check("r_valid_latency", axi.r_valid, 1);
  endtask
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst, input int mode, output logic [63:0] first);
    logic [1:0] resp_e;
    logic [63:0] exp [$];
    logic [3:0] id;
    logic user;
    bit rr, tog, done;
    int n;
    first = '0;
    resp_e = exp_resp(addr, burst, size);
    for (int i = 0; i <= int'(len); i++) exp.push_back(resp_e == 2'b00 ? model[beat_idx(addr, size, burst, i)] : 64'd0);
    id = 4'($urandom);
    user = 1'($urandom);
    ar_send(addr, len, size, burst, id, user);
    tog = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      done = 1'b0;
      while (!done && n < 100) begin
        n++;
        if (axi.r_valid) begin
          rr = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom) : tog;
          tog = !tog;
          check("r_data", axi.r_data, exp[i]);
          check("r_last", axi.r_last, i == int'(len));
          if (rr) begin
            check("r_resp", axi.r_resp, resp_e);
            check("r_id", axi.r_id, id);
            check("r_user", axi.r_user, user);
            if (i == 0) first = axi.r_data;
            done = 1'b1;
          end
          axi.r_ready = rr;
          @(negedge clock);
          axi.r_ready = 1'b0;
        end else begin
          @(negedge clock);
        end
      end
      if (!done) begin
        check("r_timeout", axi.r_valid, 1);
        break;
      end
    end
    check("r_idle", axi.r_valid, 0);
    check("ar_ready_back", axi.ar_ready, 1);
  endtask
  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst,
                           input logic [8:0] strb_arg, input logic [64:0] data_arg, input int bad, input bit gaps);
    logic [1:0] aw_e, resp_e;
    logic [3:0] id;
    logic user;
    logic [63:0] d;
    logic [7:0] s;
    int n, k, idx;
    aw_e = exp_resp(addr, burst, size);
    resp_e = (aw_e == 2'b00 && bad >= 0) ? 2'b10 : aw_e;
    id = 4'($urandom);
    user = 1'($urandom);
    axi.aw_addr = addr; axi.aw_len = len; axi.aw_size = size; axi.aw_burst = burst;
    axi.aw_id = id; axi.aw_user = user; axi.aw_qos = 4'($urandom); axi.aw_lock = 1'($urandom);
    axi.aw_valid = 1'b1;
    n = 0;
    while (!axi.aw_ready && n < 50) begin @(negedge clock); n++; end
    check("aw_ready", axi.aw_ready, 1);
    @(negedge clock);
    axi.aw_valid = 1'b0;
    check("w_ready_open", axi.w_ready, 1);
    for (int i = 0; i <= int'(len); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) @(negedge clock);
      d = data_arg[64] ? {$urandom, $urandom} : data_arg[63:0];
      s = strb_arg[8] ? 8'($urandom) : strb_arg[7:0];
      axi.w_data = d;
      axi.w_strb = s;
      axi.w_last = (i == int'(len)) ^ (i == bad);
      axi.w_valid = 1'b1;
      n = 0;
      while (!axi.w_ready && n < 50) begin @(negedge clock); n++; end
      check("w_ready", axi.w_ready, 1);
      if (aw_e == 2'b00) begin
        idx = beat_idx(addr, size, burst, i);
        for (int b = 0; b < 8; b++) if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
      end
      @(negedge clock);
      axi.w_valid = 1'b0;
      axi.w_last = 1'b0;
    end
    check("b_valid_latency", axi.b_valid, 1);
    k = $urandom_range(0, 2);
    for (int j = 0; j < k; j++) begin
      @(negedge clock);
      check("b_hold", axi.b_valid, 1);
    end
    axi.b_ready = 1'b1;
    check("b_resp", axi.b_resp, resp_e);
    check("b_id", axi.b_id, id);
    check("b_user", axi.b_user, user);
    @(negedge clock);
    axi.b_ready = 1'b0;
    check("b_drop", axi.b_valid, 0);
    check("aw_ready_back", axi.aw_ready, 1);
  endtask
  initial begin
    logic [63:0] d0, d1, old;
    logic [31:0] a;
    logic [2:0] sz;
    logic [1:0] bu;
    axi.aw_valid = 0; axi.aw_addr = 0; axi.aw_id = 0; axi.aw_user = 0; axi.aw_len = 0; axi.aw_size = 0;
    axi.aw_burst = 0; axi.aw_prot = 0; axi.aw_lock = 0; axi.aw_cache = 0; axi.aw_qos = 0;
    axi.w_valid = 0; axi.w_data = 0; axi.w_strb = 0; axi.w_last = 0; axi.b_ready = 0;
    axi.ar_valid = 0; axi.ar_addr = 0; axi.ar_id = 0; axi.ar_user = 0; axi.ar_len = 0; axi.ar_size = 0;
    axi.ar_burst = 0; axi.ar_prot = 0; axi.ar_lock = 0; axi.ar_cache = 0; axi.ar_qos = 0; axi.r_ready = 0;
    repeat (3) @(negedge clock);
    check("rst_ar_ready", axi.ar_ready, 0);
    check("rst_aw_ready", axi.aw_ready, 0);
    check("rst_w_ready", axi.w_ready, 0);
    check("rst_r_valid", axi.r_valid, 0);
    check("rst_b_valid", axi.b_valid, 0);
    check("rst_r_data", axi.r_data, 0);
    reset = 1'b0;
    @(negedge clock);
    check("ar_ready_up", axi.ar_ready, 1);
    check("aw_ready_up", axi.aw_ready, 1);
    axi.w_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("w_before_aw", axi.w_ready, 0);
    end
    axi.w_valid = 1'b0;
    for (int i = 0; i < 16; i++) axi_write(BASE + 32'(i * 2048), 8'd255, 3'd3, 2'd1, 9'h0FF, {1'b1, 64'd0}, -1, 1'b0);
    axi_write(BASE + 32'h8, 8'd0, 3'd3, 2'd1, 9'h0FF, {1'b0, 64'h1122334455667788}, -1, 1'b1);
    axi_read(BASE + 32'h8, 8'd0, 3'd3, 2'd1, 0, d0);
    check("single_read", d0, 64'h1122334455667788);
    axi_read(BASE, 8'd3, 3'd3, 2'd1, 2, d0);
    axi_write(BASE + 32'h10, 8'd0, 3'd3, 2'd1, 9'h0FF, {1'b0, 64'd0}, -1, 1'b0);
    axi_write(BASE + 32'h10, 8'd0, 3'd3, 2'd1, 9'h00F, {1'b0, 64'hFFFF_FFFF_FFFF_FFFF}, -1, 1'b0);
    axi_read(BASE + 32'h10, 8'd0, 3'd3, 2'd1, 0, d0);
    check("strobed_readback", d0, 64'h0000_0000_FFFF_FFFF);
    axi_read(32'h1000_0000, 8'd1, 3'd3, 2'd1, 1, d0);
    axi_write(BASE + 32'h20, 8'd1, 3'd3, 2'd2, 9'h0FF, {1'b1, 64'd0}, -1, 1'b1);
    axi_read(BASE + 32'h20, 8'd1, 3'd3, 2'd1, 1, d0);
    axi_write(BASE + 32'h30, 8'd2, 3'd3, 2'd1, 9'h0FF, {1'b1, 64'd0}, 1, 1'b0);
    axi_read(BASE + 32'h7FF0, 8'd3, 3'd3, 2'd1, 1, d0);
    axi_write(BASE + 32'h7FF0, 8'd3, 3'd3, 2'd1, 9'h0FF, {1'b1, 64'd0}, -1, 1'b1);
    axi_read(BASE + 32'h7FF0, 8'd3, 3'd3, 2'd1, 1, d0);
    old = model[8];
    fork
      axi_write(BASE + 32'h40, 8'd0, 3'd3, 2'd1, 9'h0FF, {1'b0, ~old}, -1, 1'b0);
      axi_read(BASE + 32'h40, 8'd0, 3'd3, 2'd1, 0, d0);
    join
    check("conc_old", d0, old);
    axi_read(BASE + 32'h40, 8'd0, 3'd3, 2'd1, 0, d1);
    check("conc_new", d1, ~old);
    for (int t = 0; t < 60; t++) begin
      a = $urandom_range(0, 7) == 0 ? $urandom : BASE + 32'($urandom_range(0, 8 * WORDS - 1));
      sz = $urandom_range(0, 6) == 0 ? 3'd4 : 3'($urandom_range(0, 3));
      bu = $urandom_range(0, 5) == 0 ? 2'($urandom_range(2, 3)) : 2'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0)
        axi_write(a, 8'($urandom_range(0, 15)), sz, bu, 9'h100, {1'b1, 64'd0}, $urandom_range(0, 9) == 0 ? 0 : -1, 1'b1);
      else
        axi_read(a, 8'($urandom_range(0, 15)), sz, bu, 1, d0);
    end
    ar_send(BASE, 8'd7, 3'd3, 2'd1, 4'h5, 1'b0);
    axi.r_ready = 1'b1;
    @(negedge clock);
    axi.r_ready = 1'b0;
    check("mid_beat2_valid", axi.r_valid, 1);
    check("mid_beat2_data", axi.r_data, model[1]);
    reset = 1'b1;
    @(negedge clock);
    check("mid_rst_r_valid", axi.r_valid, 0);
    check("mid_rst_ar_ready", axi.ar_ready, 0);
    reset = 1'b0;
    @(negedge clock);
    check("mid_ar_ready_up", axi.ar_ready, 1);
    check("mid_aw_ready_up", axi.aw_ready, 1);
    axi_read(BASE + 32'h28, 8'd2, 3'd3, 2'd1, 1, d0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
